prbs8_checker: RTL and testbench
================================

# prbs8_checker

- Receive-side counterpart of the 8-bit PRBS generator used on the TinyTapeout top level.
- Samples a serial bit stream, self-synchronises to the sequence s[n+8] = s[n] ^ s[n+4] ^ s[n+5]: a generator shifting left with feedback lfsr[7]^lfsr[3]^lfsr[2] and output lfsr[7].
- Declares lock, then counts bit errors against a locally predicted sequence.
- Sits between an input pin (or loopback of the generator output) and the status/debug outputs of the top level.

## Interface
- SYNC_BITS, 16: consecutive correct predictions required to declare lock (1..255).
- LOSS_ERRS, 4: errors within one window that drop lock (1..WINDOW).
- WINDOW, 64: valid bits per loss-of-lock observation window (power of two, ≥ 8).
- CNT_W, 16: width of err_count and bit_count.
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design enable; bits sampled only when ena & bit_valid.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  received PRBS bit.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.
- bit_count  out  CNT_W  saturating count of bits checked while locked (see Configuration).

## Operation
- A "sample" is a cycle with ena & bit_valid. Non-sample cycles: no state, register or counter changes; err_pulse = 0.
- sr[7:0] holds the last 8 bits, with sr[0] newest. pred = sr[7] ^ sr[3] ^ sr[2].
- HUNT: shift bit_in into sr and increment fill (0..8). On the 8th sample, go to VERIFY with match = 0.
- VERIFY: shift bit_in into sr (self-synchronising).
  - If bit_in == pred and sr != 0: match++.
  - Otherwise: match = 0.
  - When match reaches SYNC_BITS: go to LOCKED and clear win_cnt and win_err.
  - The all-zero sr never counts as a match, so there is no lock on a dead line.
- LOCKED (flywheel): shift pred (not bit_in) into sr. Every sample increments win_cnt and bit_count.
  - If bit_in != pred: err_pulse = 1, err_count++, win_err++.
  - If win_err reaches LOSS_ERRS: go to HUNT with fill = 0.
  - When win_cnt wraps at WINDOW: clear win_err. An error on the wrap sample counts into the new window as 1.
- Counters saturate at all-ones and do not wrap.
- clr_cnt clears err_count and bit_count. If clr_cnt coincides with an error or a counted bit, the result is 1 (clear, then count).
- Counts persist across loss and re-acquisition of lock.
- Reset (including mid-operation):
  - state HUNT; sr, fill, match, win_cnt and win_err = 0.
  - Outputs: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.

## Timing
- All outputs are registered. They reflect a sample after the rising edge that consumes it; there is no combinational path from input to output.
- err_pulse is high for exactly the one cycle following the edge that sampled the erroneous bit.
- err_count updates on that same edge.
- Clean stream from reset: locked rises after the edge consuming sample 8 + SYNC_BITS (default 24).
- Lock loss: locked falls after the edge consuming the LOSS_ERRS-th error in a window.
  - err_pulse is still asserted for that bit.
  - That bit is counted.
- Gaps in bit_valid stretch all latencies; behaviour is identical modulo idle cycles.

## Configuration
- PRBS_CHK_BITCNT_EN defined: bit_count is implemented as described.
- Undefined: no bit_count register; the bit_count port is tied to 0 and clr_cnt affects only err_count. All other behaviour is unchanged.

## Structure
- Shared package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED}.
  - Tap positions (7, 3, 2) and the generator reset seed 8'h01, so generator and checker share one definition.
- One sub-module, sat_counter (parameter W; inputs clr and inc; output q, saturating), instantiated for err_count and for bit_count.
- The remaining logic is a single FSM in prbs8_checker.

## Test plan
- Clean lock: generator (seed 8'h01) drives bit_in, bit_valid = 1 → locked = 1 after sample 24; err_count = 0 after 500 further bits; bit_count = 500 with the macro defined.
- Single error: after lock, invert one bit → err_pulse high for exactly 1 cycle, err_count = 1, locked stays 1, and the next bit is predicted correctly (flywheel).
- Lock loss: after lock, invert 4 bits within 20 samples → locked falls after the 4th error; re-acquires 24 samples later; err_count = 4 is retained.
- Window expiry: invert 3 bits, wait 64+ samples, invert 3 more → locked stays 1; err_count = 6.
- Dead line and gaps: bit_in = 0 constant for 100 samples → locked never rises. Then a clean stream with bit_valid toggling 1/0 → lock after 24 valid samples; nothing changes on idle cycles.
- Reset and clear:
  - rst_n low for one cycle mid-lock → all outputs 0 on the next cycle.
  - clr_cnt asserted together with an error → err_count = 1.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS8 definitions for generator and checker
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    localparam int         TAP_HI    = 7;
    localparam int         TAP_MID   = 3;
    localparam int         TAP_LO    = 2;
    localparam logic [7:0] PRBS_SEED = 8'h01;

    // Next bit of s[n+8] = s[n] ^ s[n+4] ^ s[n+5], with r[7] the oldest bit.
    function automatic logic prbs_fb(input logic [7:0] r);
        return r[TAP_HI] ^ r[TAP_MID] ^ r[TAP_LO];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear-then-count priority
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - self-synchronising PRBS8 checker; PRBS_CHK_BITCNT_EN enables bit_count
module prbs8_checker
    import prbs_pkg::*;
#(
    parameter int SYNC_BITS = 16,
    parameter int LOSS_ERRS = 4,
    parameter int WINDOW    = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int ERR_W = $clog2(WINDOW + 1);

    prbs_state_t       state;
    logic [7:0]        sr;
    logic [3:0]        fill;
    logic [7:0]        match;
    logic [WIN_W-1:0]  win_cnt;
    logic [ERR_W-1:0]  win_err;

    logic              sample;
    logic              pred;
    logic              mismatch;
    logic              wrap;
    logic [ERR_W-1:0]  win_err_nxt;
    logic              err_inc;
    logic              bit_inc;

    assign sample   = ena & bit_valid;
    assign pred     = prbs_fb(sr);
    assign mismatch = bit_in ^ pred;
    assign wrap     = (win_cnt == WIN_W'(WINDOW - 1));
    // The wrap sample opens the new window, so its own error is its first.
    assign win_err_nxt = wrap ? ERR_W'(mismatch) : win_err + ERR_W'(mismatch);
    assign bit_inc  = sample & (state == LOCKED);
    assign err_inc  = bit_inc & mismatch;
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_inc;
            if (sample) begin
                case (state)
                    HUNT: begin
                        sr <= {sr[6:0], bit_in};
                        if (fill == 4'd7) begin
                            state <= VERIFY;
                            fill  <= 4'd8;
                            match <= '0;
                        end else begin
                            fill <= fill + 4'd1;
                        end
                    end
                    VERIFY: begin
                        sr <= {sr[6:0], bit_in};
                        // An all-zero history predicts zero forever; never trust it.
                        if (!mismatch && (sr != 8'h00)) begin
                            if (match == 8'(SYNC_BITS - 1)) begin
                                state   <= LOCKED;
                                match   <= '0;
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                match <= match + 8'd1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        sr      <= {sr[6:0], pred};
                        win_cnt <= win_cnt + WIN_W'(1);
                        win_err <= win_err_nxt;
                        if (mismatch && (win_err_nxt == ERR_W'(LOSS_ERRS))) begin
                            state <= HUNT;
                            fill  <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (err_inc),
        .q     (err_count)
    );

`ifdef PRBS_CHK_BITCNT_EN
    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (bit_inc),
        .q     (bit_count)
    );
`else
    assign bit_count = '0;
    logic unused_bit_inc;
    assign unused_bit_inc = bit_inc;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// tb/tb_prbs8_checker.sv - randomized model-based bench for prbs8_checker
`timescale 1ns/1ps
module tb_prbs8_checker;

    localparam int SYNC_BITS = 16;
    localparam int LOSS_ERRS = 4;
    localparam int WINDOW    = 64;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    prbs8_checker #(
        .SYNC_BITS (SYNC_BITS),
        .LOSS_ERRS (LOSS_ERRS),
        .WINDOW    (WINDOW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
    int   m_mode, m_fill, m_match, m_lsamp, m_widx, m_werr, m_errc, m_bitc;
    logic hist[$];
    logic nx_pulse;

    logic exp_locked = 1'b0;
    logic exp_pulse  = 1'b0;
    int   exp_errc   = 0;
    int   exp_bitc   = 0;
    logic chk_on     = 1'b0;

    logic [7:0] gen;
    logic       dead = 1'b0;

    function automatic logic [7:0] gen_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[3] ^ r[2]};
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_lsamp = 0; m_widx = 0; m_werr = 0;
        m_errc = 0; m_bitc = 0; nx_pulse = 1'b0;
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    endtask

    task automatic push_hist(input logic b);
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic model_step(input logic s, input logic b, input logic c);
        logic p, e, nz;
        int   w;
        nx_pulse = 1'b0;
        if (c) begin
            m_errc = 0;
            m_bitc = 0;
        end
        if (s) begin
            // hist[0] is the bit 8 samples back: s[m] = s[m-8] ^ s[m-4] ^ s[m-3].
            p = hist[0] ^ hist[4] ^ hist[5];
            case (m_mode)
                0: begin
                    push_hist(b);
                    m_fill++;
                    if (m_fill == 8) begin
                        m_mode = 1;
                        m_match = 0;
                    end
                end
                1: begin
                    nz = 1'b0;
                    foreach (hist[i]) if (hist[i]) nz = 1'b1;
                    if (b == p && nz) m_match++;
                    else m_match = 0;
                    push_hist(b);
                    if (m_match == SYNC_BITS) begin
                        m_mode = 2; m_lsamp = 0; m_widx = 0; m_werr = 0;
                    end
                end
                default: begin
                    e = (b != p);
                    push_hist(p);
                    w = (m_lsamp + 1) / WINDOW;
                    if (w != m_widx) begin
                        m_widx = w;
                        m_werr = 0;
                    end
                    m_lsamp++;
                    if (m_bitc < CNT_MAX) m_bitc++;
                    if (e) begin
                        m_werr++;
                        nx_pulse = 1'b1;
                        if (m_errc < CNT_MAX) m_errc++;
                        if (m_werr == LOSS_ERRS) begin
                            m_mode = 0;
                            m_fill = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic publish();
        exp_locked = (m_mode == 2);
        exp_pulse  = nx_pulse;
        exp_errc   = m_errc;
`ifdef PRBS_CHK_BITCNT_EN
        exp_bitc   = m_bitc;
`else
        exp_bitc   = 0;
`endif
    endtask

    task automatic cycle(input logic v, input logic e, input logic inv, input logic c);
        logic s, b;
        @(negedge clk);
        rst_n = 1'b1;
        s = v & e;
        if (!s) b = 1'($urandom_range(0, 1));
        else if (dead) b = 1'b0;
        else b = gen[7] ^ inv;
        bit_valid = v;
        ena       = e;
        bit_in    = b;
        clr_cnt   = c;
        model_step(s, b, c);
        if (s && !dead) gen = gen_next(gen);
        @(posedge clk);
        #1;
        publish();
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bit_valid = 1'b0;
        ena = 1'b0;
        clr_cnt = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        publish();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("locked", int'(locked), int'(exp_locked));
            check("err_pulse", int'(err_pulse), int'(exp_pulse));
            check("err_count", int'(err_count), exp_errc);
            check("bit_count", int'(bit_count), exp_bitc);
        end
    end

    initial begin
        logic [15:0] first16;
        logic [7:0]  g;
        int          left, n;

        // The seeded generator emits its seed MSB-first, then 8'h34.
        g = 8'h01;
        for (int i = 0; i < 16; i++) begin
            first16[15 - i] = g[7];
            g = gen_next(g);
        end
        check("gen_byte0", int'(first16[15:8]), 8'h01);
        check("gen_byte1", int'(first16[7:0]), 8'h34);

        model_reset();
        do_reset();
        chk_on = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_locked", int'(locked), 0);
        check("reset_err_count", int'(err_count), 0);

        // Clean lock: 8 fill + 16 matches.
        gen = 8'h01;
        clean(23);
        check("lock_before_24", int'(locked), 0);
        clean(1);
        check("lock_at_24", int'(locked), 1);
        clean(500);
        check("clean_err_count", int'(err_count), 0);
`ifdef PRBS_CHK_BITCNT_EN
        check("clean_bit_count", int'(bit_count), 500);
`endif

        // Single error is absorbed by the flywheel.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("single_err_count", int'(err_count), 1);
        check("single_pulse", int'(err_pulse), 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("single_pulse_len", int'(err_pulse), 0);
        clean(10);
        check("single_locked", int'(locked), 1);
        check("single_err_hold", int'(err_count), 1);

        // Lock loss: align to a window start, then 4 errors within 20 samples.
        n = 0;
        while (((m_lsamp + 1) % WINDOW) != 0 && n < 2 * WINDOW) begin
            clean(1);
            n++;
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        left = 4;
        for (int i = 0; i < 20 && left > 0; i++) begin
            logic inv;
            inv = ($urandom_range(0, 19 - i) < left) ? 1'b1 : 1'b0;
            cycle(1'b1, 1'b1, inv, 1'b0);
            if (inv) left--;
        end
        check("loss_locked", int'(locked), 0);
        check("loss_err_count", int'(err_count), 4);
        clean(23);
        check("relock_before", int'(locked), 0);
        clean(1);
        check("relock_at_24", int'(locked), 1);
        check("relock_err_kept", int'(err_count), 4);

        // Window expiry: two bursts of 3 errors more than a window apart.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        clean(70);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        clean(5);
        check("window_locked", int'(locked), 1);
        check("window_err_count", int'(err_count), 6);

        // Mid-lock reset.
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset_locked", int'(locked), 0);
        check("midreset_err", int'(err_count), 0);
        check("midreset_bits", int'(bit_count), 0);

        // Dead line never locks.
        dead = 1'b1;
        clean(100);
        check("dead_locked", int'(locked), 0);
        dead = 1'b0;

        // Clean stream with bit_valid toggling.
        gen = 8'h01;
        for (int i = 0; i < 23; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("gap_before_24", int'(locked), 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_lock_at_24", int'(locked), 1);

        // clr_cnt together with an error leaves a count of 1.
        clean(3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_with_err", int'(err_count), 1);
`ifdef PRBS_CHK_BITCNT_EN
        check("clr_with_bit", int'(bit_count), 1);
`endif

        // Randomized traffic: gaps, enables, errors, clears, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0),
                      1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 199) == 0));
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
